// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared constants for the photon-counting command controller:
//   - OP_W and the opcode values carried in the top nibble of a command word
//   - the 2-bit controller state encoding
// Imported by count_controller_param and ctrl_gate_timer.
package ctrl_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP         = 4'h0;
    localparam logic [OP_W-1:0] OP_START       = 4'h1;
    localparam logic [OP_W-1:0] OP_STOP        = 4'h2;
    localparam logic [OP_W-1:0] OP_READ        = 4'h3;
    localparam logic [OP_W-1:0] OP_SET_MASK    = 4'h4;
    localparam logic [OP_W-1:0] OP_SET_TLO     = 4'h5;
    localparam logic [OP_W-1:0] OP_SET_THI     = 4'h6;
    localparam logic [OP_W-1:0] OP_START_TIMED = 4'h7;
    localparam logic [OP_W-1:0] OP_CLEAR       = 4'h8;
    localparam logic [OP_W-1:0] OP_STATUS_SNAP = 4'h9;
    localparam logic [OP_W-1:0] OP_ABORT       = 4'hF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_TIMED = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

endpackage

// File: rtl/ctrl_gate_timer.sv
// ctrl_gate_timer
// Down-counter that times a gated counting window.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset (count -> 0)
//   load       in   load count with load_value
//   enable     in   decrement while count is non-zero
//   abort      in   force count to zero
//   load_value in   TIMER_W value to load (window length minus one)
//   tc         out  terminal count, high while count == 0
module ctrl_gate_timer
    import ctrl_pkg::*;
#(
    parameter int TIMER_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               enable,
    input  logic               abort,
    input  logic [TIMER_W-1:0] load_value,
    output logic               tc
);

    logic [TIMER_W-1:0] count;

    // Abort beats load so an early stop can never leave a stale window armed.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (abort) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/count_controller_param.sv
// count_controller_param
// Command controller between the SPI slave and the photon counters. Decodes
// {opcode, argument} command words, holds the channel enable mask and the
// gate period, runs free or timed counting windows and sequences reads.
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   COMMAND        CMD_W command word, valid when CMD_VALID is high
//   CMD_VALID      one-cycle command strobe
//   DATA_ACK       readout side has captured the selected channel
//   START_COUNT    counters enabled
//   CLEAR_COUNT    one-cycle counter clear pulse
//   CH_EN          per-channel enable mask
//   READ_DATA      read request, READ_SEL selects the channel
//   BUSY           high in COUNT, TIMED or READ
//   DONE           timed window finished (sticky)
//   CMD_ERR        one-cycle pulse on an illegal or rejected command
//   STATUS         (only with COUNT_CONTROLLER_STATUS_EN) registered status word
// Optional feature macro: COUNT_CONTROLLER_STATUS_EN adds STATUS and the
// STATUS_SNAP opcode; without it opcode 0x9 is rejected.
module count_controller_param
    import ctrl_pkg::*;
#(
    parameter int CMD_W   = 16,
    parameter int N_CH    = 4,
    parameter int TIMER_W = 24,
    parameter int SEL_W   = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [CMD_W-1:0] COMMAND,
    input  logic             CMD_VALID,
    input  logic             DATA_ACK,
    output logic             START_COUNT,
    output logic             CLEAR_COUNT,
    output logic [N_CH-1:0]  CH_EN,
    output logic             READ_DATA,
    output logic [SEL_W-1:0] READ_SEL,
    output logic             BUSY,
    output logic             DONE,
    output logic             CMD_ERR
`ifdef COUNT_CONTROLLER_STATUS_EN
    ,
    output logic [15:0]      STATUS
`endif
);

    localparam int ARG_W = CMD_W - OP_W;
    localparam logic [ARG_W-1:0] N_CH_ARG = ARG_W'(N_CH);

    logic [OP_W-1:0]    opcode;
    logic [ARG_W-1:0]   arg;
    logic [ARG_W-1:0]   period_lo, period_hi;
    logic [2*ARG_W-1:0] period_full;
    logic [TIMER_W-1:0] period;
    logic [1:0]         state;

    logic [1:0]         state_n;
    logic               start_n, clear_n, read_n, done_n, err_n;
    logic [SEL_W-1:0]   sel_n;
    logic [N_CH-1:0]    mask_n;
    logic [ARG_W-1:0]   lo_n, hi_n;
    logic               timer_load, timer_abort, timer_tc;

    assign opcode      = COMMAND[CMD_W-1 -: OP_W];
    assign arg         = COMMAND[ARG_W-1:0];
    assign period_full = {period_hi, period_lo};
    assign period      = period_full[TIMER_W-1:0];
    assign BUSY        = (state != ST_IDLE);

    ctrl_gate_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk        (CLK),
        .rst        (RST),
        .load       (timer_load),
        .enable     (state == ST_TIMED),
        .abort      (timer_abort),
        .load_value (period - TIMER_W'(1)),
        .tc         (timer_tc)
    );

    // Next-state decode. The first case handles opcode legality and the
    // register writes that are accepted in every state; the second handles
    // the state-changing commands, which are only legal in some states.
    // A READ is range-checked on the whole argument so that an out-of-range
    // channel is rejected rather than silently aliased onto a low channel.
    always_comb begin
        state_n     = state;
        start_n     = START_COUNT;
        clear_n     = 1'b0;
        read_n      = READ_DATA;
        sel_n       = READ_SEL;
        done_n      = DONE;
        err_n       = 1'b0;
        mask_n      = CH_EN;
        lo_n        = period_lo;
        hi_n        = period_hi;
        timer_load  = 1'b0;
        timer_abort = 1'b0;

        if (CMD_VALID) begin
            case (opcode)
                OP_SET_MASK: mask_n = arg[N_CH-1:0];
                OP_SET_TLO:  lo_n   = arg;
                OP_SET_THI:  hi_n   = arg;
                OP_NOP, OP_START, OP_STOP, OP_READ,
                OP_START_TIMED, OP_CLEAR, OP_ABORT: ;
`ifdef COUNT_CONTROLLER_STATUS_EN
                OP_STATUS_SNAP: ;
`endif
                default:     err_n  = 1'b1;
            endcase
        end

        case (state)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    case (opcode)
                        OP_START: begin
                            state_n = ST_COUNT;
                            start_n = 1'b1;
                            done_n  = 1'b0;
                        end
                        OP_START_TIMED: begin
                            if (period == '0) begin
                                err_n = 1'b1;
                            end else begin
                                state_n    = ST_TIMED;
                                start_n    = 1'b1;
                                done_n     = 1'b0;
                                timer_load = 1'b1;
                            end
                        end
                        OP_READ: begin
                            if (arg >= N_CH_ARG) begin
                                err_n = 1'b1;
                            end else begin
                                state_n = ST_READ;
                                read_n  = 1'b1;
                                sel_n   = arg[SEL_W-1:0];
                            end
                        end
                        OP_CLEAR: begin
                            clear_n = 1'b1;
                            done_n  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_COUNT: begin
                if (CMD_VALID) begin
                    case (opcode)
                        OP_STOP, OP_ABORT: begin
                            state_n = ST_IDLE;
                            start_n = 1'b0;
                        end
                        OP_START, OP_START_TIMED, OP_READ, OP_CLEAR: err_n = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_TIMED: begin
                // Expiry has priority over a coincident STOP/ABORT so the
                // completed window is still reported through DONE.
                if (timer_tc) begin
                    state_n = ST_IDLE;
                    start_n = 1'b0;
                    done_n  = 1'b1;
                end else if (CMD_VALID && (opcode == OP_STOP || opcode == OP_ABORT)) begin
                    state_n     = ST_IDLE;
                    start_n     = 1'b0;
                    timer_abort = 1'b1;
                end
                if (CMD_VALID && (opcode == OP_START || opcode == OP_START_TIMED ||
                                  opcode == OP_READ  || opcode == OP_CLEAR)) begin
                    err_n = 1'b1;
                end
            end
            ST_READ: begin
                // An acknowledge coinciding with ABORT is taken as a normal ack.
                if (DATA_ACK || (CMD_VALID && opcode == OP_ABORT)) begin
                    state_n = ST_IDLE;
                    read_n  = 1'b0;
                end
                if (CMD_VALID && (opcode == OP_START || opcode == OP_STOP ||
                                  opcode == OP_START_TIMED || opcode == OP_READ ||
                                  opcode == OP_CLEAR)) begin
                    err_n = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Controller registers; every output except BUSY is registered here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            START_COUNT <= 1'b0;
            CLEAR_COUNT <= 1'b0;
            CH_EN       <= '1;
            READ_DATA   <= 1'b0;
            READ_SEL    <= '0;
            DONE        <= 1'b0;
            CMD_ERR     <= 1'b0;
            period_lo   <= '0;
            period_hi   <= '0;
        end else begin
            state       <= state_n;
            START_COUNT <= start_n;
            CLEAR_COUNT <= clear_n;
            CH_EN       <= mask_n;
            READ_DATA   <= read_n;
            READ_SEL    <= sel_n;
            DONE        <= done_n;
            CMD_ERR     <= err_n;
            period_lo   <= lo_n;
            period_hi   <= hi_n;
        end
    end

`ifdef COUNT_CONTROLLER_STATUS_EN
    logic        status_frozen;
    logic [15:0] status_now;

    assign status_now = {state, DONE, BUSY, 4'(READ_SEL), 8'(CH_EN)};

    // STATUS tracks the controller every cycle; STATUS_SNAP captures one
    // sample and holds it until any further command arrives.
    always_ff @(posedge CLK) begin
        if (RST) begin
            STATUS        <= '0;
            status_frozen <= 1'b0;
        end else if (CMD_VALID) begin
            STATUS        <= status_now;
            status_frozen <= (opcode == OP_STATUS_SNAP);
        end else if (!status_frozen) begin
            STATUS        <= status_now;
        end
    end
`endif

endmodule

// File: tb/tb_count_controller_param.sv
// tb_count_controller_param
// Self-checking bench for count_controller_param (default parameters).
// A cycle-level reference model predicts the outputs after every clock edge;
// predictions are queued when the stimulus is driven and compared against the
// DUT just after the edge.
module tb_count_controller_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] command = '0;
    logic        cmd_valid = 1'b0;
    logic        data_ack = 1'b0;
    logic        start_count, clear_count, read_data, busy, done, cmd_err;
    logic [3:0]  ch_en;
    logic [1:0]  read_sel;
`ifdef COUNT_CONTROLLER_STATUS_EN
    logic [15:0] status;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       start;
        logic       clear;
        logic [3:0] mask;
        logic       rd;
        logic [1:0] sel;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    int          m_state;   // 0 idle, 1 count, 2 timed, 3 read
    int          m_left;    // START_COUNT-high cycles left in a timed window
    logic        m_start, m_clear, m_rd, m_done, m_err;
    logic [3:0]  m_mask;
    logic [1:0]  m_sel;
    logic [11:0] m_lo, m_hi;

    always #5 clk = ~clk;

    count_controller_param dut (
        .CLK         (clk),
        .RST         (rst),
        .COMMAND     (command),
        .CMD_VALID   (cmd_valid),
        .DATA_ACK    (data_ack),
        .START_COUNT (start_count),
        .CLEAR_COUNT (clear_count),
        .CH_EN       (ch_en),
        .READ_DATA   (read_data),
        .READ_SEL    (read_sel),
        .BUSY        (busy),
        .DONE        (done),
        .CMD_ERR     (cmd_err)
`ifdef COUNT_CONTROLLER_STATUS_EN
        ,
        .STATUS      (status)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic modelStep(input logic r, input logic v, input logic [15:0] cmd,
                             input logic ack);
        logic [3:0]  op;
        logic [11:0] a;
        logic [23:0] per;
        logic        legal;
        int          st;
        op  = cmd[15:12];
        a   = cmd[11:0];
        per = {m_hi, m_lo};
        st  = m_state;
        if (r) begin
            m_state = 0; m_left = 0; m_start = 0; m_clear = 0; m_rd = 0;
            m_done = 0; m_err = 0; m_mask = 4'hF; m_sel = 0; m_lo = 0; m_hi = 0;
            return;
        end
        m_clear = 0;
        m_err   = 0;
        if (v) begin
            legal = (op <= 4'h8) || (op == 4'hF);
`ifdef COUNT_CONTROLLER_STATUS_EN
            if (op == 4'h9) legal = 1'b1;
`endif
            if (!legal) m_err = 1;
            if (op == 4'h4) m_mask = a[3:0];
            if (op == 4'h5) m_lo = a;
            if (op == 4'h6) m_hi = a;
        end
        case (st)
            0: if (v) begin
                if (op == 4'h1) begin
                    m_state = 1; m_start = 1; m_done = 0;
                end else if (op == 4'h7) begin
                    if (per == 0) m_err = 1;
                    else begin
                        m_state = 2; m_start = 1; m_done = 0; m_left = int'(per);
                    end
                end else if (op == 4'h3) begin
                    if (a >= 12'd4) m_err = 1;
                    else begin
                        m_state = 3; m_rd = 1; m_sel = a[1:0];
                    end
                end else if (op == 4'h8) begin
                    m_clear = 1; m_done = 0;
                end
            end
            1: if (v) begin
                if (op == 4'h2 || op == 4'hF) begin
                    m_state = 0; m_start = 0;
                end else if (op == 4'h1 || op == 4'h3 || op == 4'h7 || op == 4'h8) begin
                    m_err = 1;
                end
            end
            2: begin
                if (m_left == 1) begin
                    m_state = 0; m_start = 0; m_done = 1; m_left = 0;
                end else if (v && (op == 4'h2 || op == 4'hF)) begin
                    m_state = 0; m_start = 0; m_left = 0;
                end else begin
                    m_left--;
                end
                if (v && (op == 4'h1 || op == 4'h3 || op == 4'h7 || op == 4'h8)) m_err = 1;
            end
            default: begin
                if (ack || (v && op == 4'hF)) begin
                    m_state = 0; m_rd = 0;
                end
                if (v && (op == 4'h1 || op == 4'h2 || op == 4'h3 || op == 4'h7 || op == 4'h8))
                    m_err = 1;
            end
        endcase
    endtask

    // Drive one cycle of inputs, queue the predicted outputs, then compare
    // them against the DUT just after the clock edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [15:0] cmd,
                                 input logic ack);
        exp_t e;
        @(negedge clk);
        rst       = r;
        cmd_valid = v;
        command   = cmd;
        data_ack  = ack;
        modelStep(r, v, cmd, ack);
        e.start = m_start; e.clear = m_clear; e.mask = m_mask; e.rd = m_rd;
        e.sel = m_sel; e.busy = (m_state != 0); e.done = m_done; e.err = m_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checkOutput("START_COUNT", 32'(start_count), 32'(e.start));
        checkOutput("CLEAR_COUNT", 32'(clear_count), 32'(e.clear));
        checkOutput("CH_EN",       32'(ch_en),       32'(e.mask));
        checkOutput("READ_DATA",   32'(read_data),   32'(e.rd));
        checkOutput("READ_SEL",    32'(read_sel),    32'(e.sel));
        checkOutput("BUSY",        32'(busy),        32'(e.busy));
        checkOutput("DONE",        32'(done),        32'(e.done));
        checkOutput("CMD_ERR",     32'(cmd_err),     32'(e.err));
    endtask

    task automatic cmd(input logic [15:0] c);
        applyStimulus(1'b0, 1'b1, c, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        // Reset state
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);

        // Free-running window
        cmd(16'h1000); idle(49); cmd(16'h2000); idle(3);

        // 100-cycle timed window
        cmd(16'h5064); cmd(16'h6000); cmd(16'h7000); idle(104);

        // Mask then start, back-to-back commands
        cmd(16'h4005); cmd(16'h1000); idle(2); cmd(16'h2000); idle(1);

        // Read handshake; ack outside READ is ignored
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        cmd(16'h3002); idle(6);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1); idle(2);
        cmd(16'h3005); idle(2);

        // Rejections and abort inside a timed window, bad opcode in IDLE
        cmd(16'h7000); idle(10); cmd(16'h3001); idle(5); cmd(16'hF000); idle(2);
        cmd(16'hB000); idle(1); cmd(16'h9000); idle(1);

        // Read-state rejections and ack coinciding with ABORT
        cmd(16'h3001); cmd(16'h1000); idle(2);
        applyStimulus(1'b0, 1'b1, 16'hF000, 1'b1); idle(1);
        cmd(16'h3003); cmd(16'hF000); idle(1);

        // Clear clears DONE, and STOP coinciding with expiry still sets DONE
        cmd(16'h5005); cmd(16'h7000); idle(4); cmd(16'h2000); idle(2);
        cmd(16'h8000); idle(2);

        // Count-state rejections, period of one cycle
        cmd(16'h1000); cmd(16'h8000); cmd(16'h7000); cmd(16'hF000); idle(1);
        cmd(16'h5001); cmd(16'h7000); idle(3);

        // Zero period rejected; reset mid-window
        cmd(16'h5000); cmd(16'h7000); idle(2);
        cmd(16'h5005); cmd(16'h4003); cmd(16'h7000); idle(2);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0); idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/count_controller_param.md
Name: count_controller_param

Overview:
- Parametrised command controller for the photon-counting datapath.
- Sits between the SPI slave, which delivers a command word plus a valid strobe, and the counter/readout logic.
- Decodes an opcode/argument command word, holds a per-channel enable mask, and runs free or timed counting windows from a programmable gate timer.
- Sequences a read handshake that selects one channel for readout.

Parameters:
- CMD_W, 16, command word width; opcode = CMD[CMD_W-1:CMD_W-4], argument = CMD[CMD_W-5:0]
- N_CH, 4, number of counter channels (1..12)
- TIMER_W, 24, gate timer width; must be <= 2*(CMD_W-4)
- SEL_W, 2, channel select width, >= clog2(N_CH)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- COMMAND  in  CMD_W  command word from SPI
- CMD_VALID  in  1  one-cycle strobe; COMMAND is valid on this rising edge
- DATA_ACK  in  1  readout side has captured the selected channel
- START_COUNT  out  1  counters enabled (gated by CH_EN)
- CLEAR_COUNT  out  1  one-cycle pulse; zero all counters
- CH_EN  out  N_CH  per-channel enable mask
- READ_DATA  out  1  read request to readout logic
- READ_SEL  out  SEL_W  channel to read
- BUSY  out  1  high in COUNT, TIMED or READ
- DONE  out  1  timed window finished; sticky until next START/START_TIMED/CLEAR
- CMD_ERR  out  1  one-cycle pulse on an illegal or rejected command

Behaviour:
- Reset: all outputs 0, except CH_EN = all ones. Gate period = 0; state IDLE. Reset mid-operation aborts any window or read immediately.
- Commands act only when CMD_VALID = 1. Decode latency is 1 cycle: outputs change on the edge after the CMD_VALID edge.
- Opcodes:
  - 0x0 NOP: no effect.
  - 0x1 START: free-running count.
  - 0x2 STOP: end count.
  - 0x3 READ: arg[SEL_W-1:0] gives the channel.
  - 0x4 SET_MASK: arg[N_CH-1:0] gives the mask.
  - 0x5 SET_TLO: period low half.
  - 0x6 SET_THI: period high half.
  - 0x7 START_TIMED: timed window.
  - 0x8 CLEAR: clear counters.
  - 0xF ABORT.
  - Any other opcode -> CMD_ERR.
- States: IDLE, COUNT, TIMED, READ.
- IDLE:
  - START -> COUNT; START_COUNT = 1, DONE = 0.
  - START_TIMED with period != 0 -> TIMED; timer loaded with period-1, START_COUNT = 1, DONE = 0.
  - START_TIMED with period = 0 -> CMD_ERR, stay IDLE.
  - READ -> READ; READ_DATA = 1, READ_SEL latched.
  - READ with sel >= N_CH -> CMD_ERR, stay IDLE.
  - CLEAR -> CLEAR_COUNT pulse, DONE = 0.
- COUNT:
  - STOP or ABORT -> IDLE; START_COUNT = 0.
  - READ, START, START_TIMED, CLEAR -> CMD_ERR, ignored.
- TIMED:
  - Timer decrements each cycle; START_COUNT is high for exactly `period` cycles.
  - At timer = 0: -> IDLE, START_COUNT = 0, DONE = 1.
  - STOP or ABORT -> IDLE early, DONE stays 0.
  - Other state-changing commands -> CMD_ERR.
- READ:
  - READ_DATA held until DATA_ACK = 1. On that edge -> IDLE, READ_DATA = 0.
  - ABORT -> IDLE without ack.
  - Other state-changing commands -> CMD_ERR.
- SET_MASK, SET_TLO, SET_THI are accepted in any state.
  - In TIMED, the new period takes effect on the next window only.
  - SET_MASK takes effect on CH_EN next cycle.
- Width: period = {THI, TLO} truncated to TIMER_W. SET_TLO writes bits [CMD_W-5:0]; SET_THI writes the next CMD_W-4 bits. Unused argument bits are ignored.
- Simultaneous CMD_VALID STOP and timer expiry: expiry wins, DONE = 1.
- Simultaneous DATA_ACK and ABORT: treated as ack.
- DATA_ACK outside READ is ignored.
- CMD_VALID held high on consecutive cycles: each cycle is a separate command.

Optional Feature:
- Macro: COUNT_CONTROLLER_STATUS_EN.
- Defined: extra output STATUS[15:0] = {state[1:0], DONE, BUSY, READ_SEL padded to 4 bits, CH_EN padded to 8 bits}, registered and updated every cycle.
- Opcode 0x9 STATUS_SNAP freezes STATUS until the next command.
- Undefined: no STATUS port, and 0x9 raises CMD_ERR.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants OP_NOP..OP_ABORT and OP_STATUS_SNAP
  - state encoding ST_IDLE..ST_READ (2 bits)
  - OP_W = 4
- One sub-module, ctrl_gate_timer, contains the TIMER_W down-counter with load/enable/abort and a terminal-count output.

Test Plan:
- RST, then START (0x1000), then 50 cycles, then STOP (0x2000) -> START_COUNT high 50 cycles after 1-cycle latency; BUSY tracks it; DONE = 0.
- SET_TLO 0x0064, SET_THI 0x0000, START_TIMED 0x7000 -> START_COUNT high exactly 100 cycles, then DONE = 1, BUSY = 0.
- SET_MASK 0x4005 then START -> CH_EN = 4'b0101 and START_COUNT = 1.
- READ 0x3002 -> READ_DATA = 1, READ_SEL = 2; DATA_ACK after 7 cycles -> READ_DATA = 0, state IDLE. READ 0x3005 with N_CH = 4 -> CMD_ERR pulse, no read.
- During a TIMED window: READ 0x3001 -> CMD_ERR; ABORT 0xF000 -> START_COUNT = 0, DONE = 0. Opcode 0xB000 in IDLE -> CMD_ERR.
- START_TIMED with period 0 -> CMD_ERR. RST asserted mid-TIMED -> all outputs at reset values next cycle, CH_EN = all ones.
